brcomp_iter: RTL and testbench

// Parametrised multi-cycle branch comparator: successor to the combinational brcomp.

---
 rtl/brcomp_iter_if.sv | 28 ++
 rtl/brcomp_iter.sv | 134 +++++++++++++
 tb/tb_brcomp_iter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/brcomp_iter_if.sv
// brcomp_iter_if: the request and result handshake bundle for the multi-cycle branch comparator.
//   Request : in_valid, in_ready, rs1_data, rs2_data, I_U, flush
//   Result  : out_valid, out_ready, less, equal
// The master modport is the execute/branch-resolution side. The slave modport is the comparator.
interface brcomp_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            I_U;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            less;
  logic            equal;

  modport master (
    output in_valid, rs1_data, rs2_data, I_U, flush, out_ready,
    input  in_ready, out_valid, less, equal
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, I_U, flush, out_ready,
    output in_ready, out_valid, less, equal
  );
endinterface

// File: rtl/brcomp_iter.sv
// brcomp_iter: multi-cycle branch comparator. It compares two XLEN-bit operands
// CHUNK bits per cycle, starting with the most significant chunk. The compare can
// be signed or unsigned, and the less/equal result is returned through a
// valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : brcomp_iter_if.slave (request handshake, operands, I_U, flush,
//           result handshake, less, equal)
// Optional build macro BRCOMP_EARLY_EXIT_EN: the scan stops on the first
// differing chunk. Without it, every compare takes NCHUNK edges.
module brcomp_iter #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  brcomp_iter_if.slave bus
);
  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             hit;
  logic             last;

  assign chunk_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
  // hit is the first differing chunk seen from the top. Later chunks cannot change the result.
  assign hit     = !decided_q && (chunk_a != chunk_b);
  assign last    = (idx_q == '0);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    decided_d   = decided_q;
    less_d      = less_q;
    equal_d     = equal_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Flipping the MSB of both operands for a signed compare turns the
          // whole job into an unsigned compare.
          a_d       = {bus.rs1_data[XLEN-1] ^ ~bus.I_U, bus.rs1_data[XLEN-2:0]};
          b_d       = {bus.rs2_data[XLEN-1] ^ ~bus.I_U, bus.rs2_data[XLEN-2:0]};
          idx_d     = IDX_W'(NCHUNK - 1);
          decided_d = 1'b0;
          less_d    = 1'b0;
          equal_d   = 1'b0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          decided_d = 1'b1;
          less_d    = (chunk_a < chunk_b);
        end
`ifdef BRCOMP_EARLY_EXIT_EN
        if (hit || last) begin
`else
        if (last) begin
`endif
          equal_d     = !(decided_q || hit);
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // A flush has priority over everything above. It kills a capture, a scan in
    // progress, or a pending result.
    if (bus.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      less_d      = 1'b0;
      equal_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      decided_q   <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      decided_q   <= decided_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.less      = less_q;
  assign bus.equal     = equal_q;
endmodule

// File: tb/tb_brcomp_iter.sv
module tb_brcomp_iter;
  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  brcomp_iter_if #(.XLEN(XLEN)) bus ();

  brcomp_iter #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the result comes from a plain full-width compare. The
  // latency comes from the position of the first differing chunk.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic iu,
                       output logic exp_less, output logic exp_equal, output int exp_lat);
    exp_equal = (a == b);
    exp_less  = iu ? (a < b) : ($signed(a) < $signed(b));
    exp_lat   = NCHUNK;
`ifdef BRCOMP_EARLY_EXIT_EN
    for (int k = 1; k <= NCHUNK; k++) begin
      if (a[(NCHUNK-k)*CHUNK +: CHUNK] != b[(NCHUNK-k)*CHUNK +: CHUNK]) begin
        exp_lat = k;
        break;
      end
    end
`endif
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic iu);
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.I_U      = iu;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid and returns the number of edges that took after the
  // accepting edge. A return value of 99 means the wait timed out.
  task automatic wait_result(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic iu, input string tag);
    logic el, eq;
    int   lat, cyc;
    model(a, b, iu, el, eq, lat);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    accept(a, b, iu);
    wait_result(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_less"},    32'(bus.less),  32'(el));
    check({tag, "_equal"},   32'(bus.equal), 32'(eq));
    check({tag, "_excl"},    32'(bus.less & bus.equal), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int          cyc;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.I_U       = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_less",      32'(bus.less),      32'd0);
    check("rst_equal",     32'(bus.equal),     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors.
    run_op(32'h00000010, 32'h00000010, 1'b0, "eq_signed");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "neg1_vs_1_s");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, "neg1_vs_1_u");
    run_op(32'h80000000, 32'h00000000, 1'b0, "min_vs_0_s");
    run_op(32'h80000000, 32'h00000000, 1'b1, "min_vs_0_u");
    run_op(32'h12345678, 32'h12345679, 1'b1, "lsb_diff_u");
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b0, "max_vs_min_s");
    run_op(32'h00000000, 32'h00000000, 1'b1, "zero_eq_u");

    // Random operands. Both sides share a prefix so that every chunk position can be the deciding one.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = a;
      if ($urandom_range(0, 4) != 0) begin
        int p;
        p = $urandom_range(0, NCHUNK - 1);
        b[p*CHUNK +: CHUNK] = 8'($urandom);
        if ($urandom_range(0, 1) != 0) b[p*CHUNK +: CHUNK] = a[p*CHUNK +: CHUNK] ^ 8'h80;
      end
      run_op(a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    // Backpressure in DONE while the source keeps in_valid high.
    accept(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_result(cyc);
    check("bp_reached_done", 32'(cyc < 99), 32'd1);
    bus.in_valid = 1'b1;
    bus.rs1_data = 32'h00000005;
    bus.rs2_data = 32'h00000005;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid%0d", i),    32'(bus.out_valid), 32'd1);
      check($sformatf("bp_less%0d", i),     32'(bus.less),      32'd1);
      check($sformatf("bp_equal%0d", i),    32'(bus.equal),     32'd0);
      check($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready),  32'd1);
    expect_quiet("bp_no_second_capture", 6);

    // Flush on the second SCAN edge. Equal operands keep early exit from finishing first.
    accept(32'h55555555, 32'h55555555, 1'b1);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_scan_ready", 32'(bus.in_ready),  32'd1);
    check("flush_scan_valid", 32'(bus.out_valid), 32'd0);
    expect_quiet("flush_scan_quiet", 6);

    // A flush in IDLE blocks the request from being accepted.
    bus.rs1_data = 32'h1;
    bus.rs2_data = 32'h2;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_idle_not_taken", 32'(bus.in_ready), 32'd1);
    expect_quiet("flush_idle_quiet", 6);

    // A flush together with the result handshake drops the result.
    accept(32'h00000003, 32'h00000009, 1'b1);
    wait_result(cyc);
    check("flush_done_reached", 32'(cyc < 99), 32'd1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    check("flush_done_valid", 32'(bus.out_valid), 32'd0);
    check("flush_done_ready", 32'(bus.in_ready),  32'd1);
    run_op(32'h00000009, 32'h00000003, 1'b1, "after_flush");

    // Asynchronous reset in the middle of an operation.
    accept(32'h80000000, 32'h00000000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid",    32'(bus.out_valid), 32'd0);
    check("arst_less",     32'(bus.less),      32'd0);
    check("arst_equal",    32'(bus.equal),     32'd0);
    check("arst_in_ready", 32'(bus.in_ready),  32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", 32'(bus.in_ready), 32'd1);
    expect_quiet("arst_quiet", 6);
    run_op(32'h00000001, 32'hFFFFFFFF, 1'b0, "after_arst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
